biquad_notch_tdm: RTL
=====================

BIQUAD_NOTCH_TDM -- requirements
Module: biquad_notch_tdm

Interface
REQ-001 Parameter DW, default 16: signed sample width.
REQ-002 Parameter CW, default 18: signed coefficient width.
REQ-003 Parameter FRAC, default 14: coefficient fractional bits, so 1.0 = 2^FRAC.
REQ-004 Parameter CH, default 2: channel count; CHW = max(1, clog2(CH)).
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  in  1  input sample offered.
REQ-008 in_ready  out  1  block can accept a sample.
REQ-009 in_ch  in  CHW  channel of the offered sample.
REQ-010 in_data  in  DW  signed input sample.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 out_ch  out  CHW  channel of the result.
REQ-014 out_data  out  DW  signed filtered sample.
REQ-015 cfg_we  in  1  coefficient write strobe.
REQ-016 cfg_clr  in  1  history-clear strobe for cfg_ch.
REQ-017 cfg_ch  in  CHW  target channel for cfg_we and cfg_clr.
REQ-018 cfg_idx  in  3  coefficient index: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; values 5-7 are ignored.
REQ-019 cfg_data  in  CW  signed coefficient value.
REQ-020 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-021 Each channel computes y[n] = (b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2] + 2^(FRAC-1)) >>> FRAC.
REQ-022 Each channel keeps its own coefficient set and history (x1, x2, y1, y2).
REQ-023 A single shared multiplier-accumulator performs one product per cycle.
REQ-024 The accumulator is DW+CW+3 bits wide and never overflows internally.
REQ-025 FSM states are IDLE, MAC0 through MAC4, and OUT.
- IDLE -> MAC0 on in_valid & in_ready.
- MACk -> MAC(k+1) each cycle.
- MAC4 -> OUT.
- OUT -> IDLE on out_ready.
REQ-026 in_ready SHALL equal (state == IDLE); the sample and channel are captured on the accept cycle.
REQ-027 At acceptance, all five coefficients of the channel are copied into a working set, so cfg writes during MAC never alter the sample in flight.
REQ-028 out_valid SHALL rise 6 cycles after the accept edge (accept on cycle 0, out_valid on cycle 6).
REQ-029 out_valid, out_ch and out_data SHALL stay stable until the out_ready handshake; this gives a throughput of at most one sample per 7 cycles.
REQ-030 The channel history shifts on the MAC4 -> OUT edge: x2 <= x1, x1 <= x, y2 <= y1, y1 <= y, where y is the post-rounding DW-bit value.
REQ-031 cfg_we takes effect on the next edge and is accepted in any state.
REQ-032 cfg_clr zeroes the history of cfg_ch on the next edge.
REQ-033 If cfg_clr targets the channel in flight, the clear wins over the MAC4 history update; out_data is still produced.
REQ-034 An in_ch value >= CH is accepted and produces out_data = 0 with no state change.

Reset
REQ-035 While rst_n is low:
- state = IDLE; out_valid = 0; out_data = 0; out_ch = 0; busy = 0.
- All histories = 0.
- Coefficients: b0 = 2^FRAC, all others = 0 (pass-through).
REQ-036 Reset asserted mid-operation discards the sample in flight; no output is produced for it.

Configuration
REQ-037 Macro BIQUAD_NOTCH_SAT_EN defined: the rounded result saturates to [-2^(DW-1), 2^(DW-1)-1], and the saturated value is both output and stored.
REQ-038 BIQUAD_NOTCH_SAT_EN undefined: the result is truncated two's-complement (wraps).

Structure
REQ-039 A shared package biquad_notch_pkg holds the coefficient-index constants, the FSM state enum and the accumulator-width function.
REQ-040 One sub-module, biquad_mac, holds the multiplier, accumulator, rounding and saturation logic; the FSM, coefficient RAM and history registers sit in the top module.

Verification
REQ-041 After reset, with DW=16, FRAC=14, in 1000 on ch0 -> out_data 1000, out_ch 0, out_valid on cycle 6.
REQ-042 Coefficients b=[8192, 0, 8192], a=[0, 0]; inputs 0, 1000, 0, -1000, 0, 1000 (fs/4 tone) -> outputs 0, 500, 0, 0, 0, 0 (notch).
REQ-043 b0=16384, b1=16384; inputs 32767, 32767 -> second out 32767 with SAT_EN, -2 without.
REQ-044 out_ready held low 10 cycles -> out_valid, out_data and out_ch stable, in_ready low; release -> a single handshake, then in_ready high next cycle.
REQ-045 Interleave ch0 and ch1 with distinct coefficients -> the results match independent per-channel models; a cfg_we to ch0 during MAC2 does not change the in-flight result.
REQ-046 rst_n low during MAC3 -> no out_valid; history and coefficients return to reset values.

Source files
------------

// File: rtl/biquad_notch_pkg.sv
// Shared definitions for the time-multiplexed biquad notch filter.
//   - Coefficient index map used on the cfg_idx port (b0, b1, b2, a1, a2).
//   - FSM state encoding for the top-level sequencer.
//   - Accumulator width helper used by the MAC datapath.
package biquad_notch_pkg;

    localparam int unsigned NumCoef = 5;

    localparam logic [2:0] IdxB0 = 3'd0;
    localparam logic [2:0] IdxB1 = 3'd1;
    localparam logic [2:0] IdxB2 = 3'd2;
    localparam logic [2:0] IdxA1 = 3'd3;
    localparam logic [2:0] IdxA2 = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StMac0,
        StMac1,
        StMac2,
        StMac3,
        StMac4,
        StOut
    } state_e;

    // Five full-width products plus the rounding offset fit in three guard bits.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cw);
        return dw + cw + 3;
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// Shared multiply-accumulate unit: one signed coefficient x sample product per enabled cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          accumulate this cycle
//   first       start a new sum (ignore the old accumulator contents)
//   sub         subtract the product instead of adding it (feedback terms)
//   coef        signed CW-bit coefficient
//   operand     signed DW-bit sample
//   result      rounded, rescaled DW-bit value of the sum including this cycle's product
// Build option: BIQUAD_NOTCH_SAT_EN clamps the result to the DW-bit range; otherwise it wraps.
module biquad_mac
    import biquad_notch_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 18,
    parameter int unsigned FRAC = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 first,
    input  logic                 sub,
    input  logic signed [CW-1:0] coef,
    input  logic signed [DW-1:0] operand,
    output logic signed [DW-1:0] result
);

    localparam int unsigned AW = acc_width(DW, CW);
    localparam int unsigned PW = DW + CW;

    localparam logic signed [AW-1:0] RoundHalf = AW'(1) << (FRAC - 1);
    localparam logic signed [AW-1:0] MaxVal = {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [AW-1:0] MinVal = {{(AW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] acc_base;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] rounded;
    logic signed [AW-1:0] scaled;

    always_comb begin
        prod     = coef * operand;
        prod_ext = AW'(prod);
        acc_base = first ? '0 : acc_q;
        acc_d    = sub ? (acc_base - prod_ext) : (acc_base + prod_ext);
        rounded  = acc_d + RoundHalf;
        scaled   = rounded >>> FRAC;
    end

`ifdef BIQUAD_NOTCH_SAT_EN
    always_comb begin
        if (scaled > MaxVal) begin
            result = MaxVal[DW-1:0];
        end else if (scaled < MinVal) begin
            result = MinVal[DW-1:0];
        end else begin
            result = scaled[DW-1:0];
        end
    end
`else
    always_comb begin
        result = scaled[DW-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/biquad_notch_tdm.sv
// Multi-channel direct-form-I biquad sharing one MAC across channels (one sample in flight).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_ch/in_data input sample handshake
//   out_valid/out_ready/out_ch/out_data  result handshake, held until accepted
//   cfg_we/cfg_idx/cfg_data         coefficient write (b0,b1,b2,a1,a2) to cfg_ch
//   cfg_clr                         zero the history of cfg_ch
//   busy                            sequencer not idle
// Build option: BIQUAD_NOTCH_SAT_EN selects saturating instead of wrapping output.
module biquad_notch_tdm
    import biquad_notch_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 18,
    parameter int unsigned FRAC = 14,
    parameter int unsigned CH   = 2,
    parameter int unsigned CHW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHW-1:0]       in_ch,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHW-1:0]       out_ch,
    output logic signed [DW-1:0] out_data,
    input  logic                 cfg_we,
    input  logic                 cfg_clr,
    input  logic [CHW-1:0]       cfg_ch,
    input  logic [2:0]           cfg_idx,
    input  logic signed [CW-1:0] cfg_data,
    output logic                 busy
);

    localparam logic signed [CW-1:0] Unity = CW'(1) << FRAC;

    logic signed [CW-1:0] coef_q [CH][NumCoef];
    logic signed [DW-1:0] x1_q [CH];
    logic signed [DW-1:0] x2_q [CH];
    logic signed [DW-1:0] y1_q [CH];
    logic signed [DW-1:0] y2_q [CH];

    // Working set snapshot taken at acceptance; w_op[0] is the sample itself.
    logic signed [CW-1:0] w_coef [NumCoef];
    logic signed [DW-1:0] w_op [NumCoef];

    state_e               state_q;
    logic [CHW-1:0]       ch_q;
    logic                 ch_ok_q;
    logic [CHW-1:0]       out_ch_q;
    logic signed [DW-1:0] out_data_q;

    logic                 in_ok;
    logic                 cfg_ok;
    logic [2:0]           step;
    logic                 mac_en;
    logic                 mac_first;
    logic                 mac_sub;
    logic signed [DW-1:0] mac_y;

    assign in_ok     = 32'(in_ch) < CH;
    assign cfg_ok    = 32'(cfg_ch) < CH;
    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StOut);
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

    always_comb begin
        step   = IdxB0;
        mac_en = 1'b1;
        unique case (state_q)
            StMac0:  step = IdxB0;
            StMac1:  step = IdxB1;
            StMac2:  step = IdxB2;
            StMac3:  step = IdxA1;
            StMac4:  step = IdxA2;
            default: mac_en = 1'b0;
        endcase
        mac_first = (state_q == StMac0);
        mac_sub   = (step >= IdxA1);
    end

    biquad_mac #(
        .DW   (DW),
        .CW   (CW),
        .FRAC (FRAC)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (mac_en),
        .first   (mac_first),
        .sub     (mac_sub),
        .coef    (w_coef[step]),
        .operand (w_op[step]),
        .result  (mac_y)
    );

    // Sequencer, working set and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            ch_ok_q    <= 1'b0;
            out_ch_q   <= '0;
            out_data_q <= '0;
            for (int k = 0; k < NumCoef; k++) begin
                w_coef[k] <= '0;
                w_op[k]   <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q <= StMac0;
                        ch_q    <= in_ch;
                        ch_ok_q <= in_ok;
                        w_op[0] <= in_data;
                        if (in_ok) begin
                            for (int k = 0; k < NumCoef; k++) begin
                                w_coef[k] <= coef_q[in_ch][k];
                            end
                            w_op[1] <= x1_q[in_ch];
                            w_op[2] <= x2_q[in_ch];
                            w_op[3] <= y1_q[in_ch];
                            w_op[4] <= y2_q[in_ch];
                        end else begin
                            // Unknown channel: zero coefficients force a zero result.
                            for (int k = 0; k < NumCoef; k++) begin
                                w_coef[k] <= '0;
                            end
                            for (int k = 1; k < NumCoef; k++) begin
                                w_op[k] <= '0;
                            end
                        end
                    end
                end
                StMac0: state_q <= StMac1;
                StMac1: state_q <= StMac2;
                StMac2: state_q <= StMac3;
                StMac3: state_q <= StMac4;
                StMac4: begin
                    state_q    <= StOut;
                    out_ch_q   <= ch_q;
                    out_data_q <= ch_ok_q ? mac_y : '0;
                end
                StOut: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Coefficient RAM and per-channel history; a clear is applied last so it beats the shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < NumCoef; k++) begin
                    coef_q[c][k] <= (k == 0) ? Unity : '0;
                end
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
            end
        end else begin
            if (cfg_we && cfg_ok && (cfg_idx <= IdxA2)) begin
                coef_q[cfg_ch][cfg_idx] <= cfg_data;
            end
            if ((state_q == StMac4) && ch_ok_q) begin
                x2_q[ch_q] <= x1_q[ch_q];
                x1_q[ch_q] <= w_op[0];
                y2_q[ch_q] <= y1_q[ch_q];
                y1_q[ch_q] <= mac_y;
            end
            if (cfg_clr && cfg_ok) begin
                x1_q[cfg_ch] <= '0;
                x2_q[cfg_ch] <= '0;
                y1_q[cfg_ch] <= '0;
                y2_q[cfg_ch] <= '0;
            end
        end
    end

endmodule
